// File: rtl/text_field_writer_pkg.sv
// Shared constants and types for the text-mode field writers.
// Holds ASCII codes, default screen geometry and the writer state encoding.
package text_field_writer_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int unsigned DEF_COLS  = 80;
  localparam int unsigned DEF_ROWS  = 60;
  localparam int unsigned DEF_ADDRW = 13;

  localparam int unsigned ROW_W  = 6;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned CHAR_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // A character that may belong to a leading-zero region.
  function automatic logic is_lead_char(input logic [7:0] c);
    return (c == ASCII_SPACE) || (c == ASCII_ZERO);
  endfunction

endpackage

// File: rtl/text_cell_addr.sv
// Maps a (row, col) text cell to its linear character-RAM address.
// Also flags positions that fall outside the visible screen.
module text_cell_addr
  import text_field_writer_pkg::*;
#(
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned ADDRW = DEF_ADDRW
) (
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic [ADDRW-1:0] o_base_c,
  output logic             o_oor_c
);

  logic [ADDRW-1:0] w_row_off;

  assign w_row_off = ADDRW'(i_row) * ADDRW'(COLS);
  assign o_base_c  = w_row_off + ADDRW'(i_col);
  assign o_oor_c   = (32'(i_row) >= ROWS) || (32'(i_col) >= COLS);

endmodule

// File: rtl/text_field_writer.sv
// Writes one fixed-width ASCII field into the text-mode character RAM,
// one character per clock, with optional leading-zero blanking and right-edge clipping.
module text_field_writer
  import text_field_writer_pkg::*;
#(
  parameter int unsigned NCHARS = 6,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDRW  = DEF_ADDRW
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iVALID,
  output logic                       oREADY,
  input  logic [NCHARS*CHAR_W-1:0]   iTEXT,
  input  logic [ROW_W-1:0]           iROW,
  input  logic [COL_W-1:0]           iCOL,
  input  logic                       iBLANK_LZ,
  output logic                       oWE,
  output logic [ADDRW-1:0]           oADDR,
  output logic [CHAR_W-1:0]          oDATA,
  output logic                       oDONE
);

  localparam int unsigned TW = NCHARS * CHAR_W;
  localparam int unsigned KW = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int unsigned SW = COL_W + 1;

  state_t           r_state, w_state_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [TW-1:0]    r_text;
  logic [COL_W-1:0] r_col;
  logic [ADDRW-1:0] r_base;
  logic             r_oor;
  logic             r_blanking, w_blanking_nxt;

  logic             r_ready, w_ready_nxt;
  logic             r_we, w_we_nxt;
  logic [ADDRW-1:0] r_addr, w_addr_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_done, w_done_nxt;

  logic [ADDRW-1:0] w_base;
  logic             w_oor;
  logic             w_accept;

  logic [TW-1:0]    w_src_text;
  logic [COL_W-1:0] w_src_col;
  logic [ADDRW-1:0] w_src_base;
  logic             w_src_oor;
  logic             w_src_blank;
  logic [KW-1:0]    w_slot;
  logic [7:0]       w_char;
  logic [SW-1:0]    w_col_sum;
  logic             w_slot_we;
  logic             w_last;
  logic             w_in_region;
  logic [7:0]       w_out_char;
  logic [ADDRW-1:0] w_slot_addr;

  text_cell_addr #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDRW (ADDRW)
  ) u_cell_addr (
    .i_row    (iROW),
    .i_col    (iCOL),
    .o_base_c (w_base),
    .o_oor_c  (w_oor)
  );

  assign w_accept = (r_state == ST_IDLE) && iVALID && r_ready;

  // Slot 0 comes straight from the request; later slots from the latched copy.
  always_comb begin
    w_src_text  = r_text;
    w_src_col   = r_col;
    w_src_base  = r_base;
    w_src_oor   = r_oor;
    w_src_blank = r_blanking;
    w_slot      = r_k + KW'(1);
    if (r_state == ST_IDLE) begin
      w_src_text  = iTEXT;
      w_src_col   = iCOL;
      w_src_base  = w_base;
      w_src_oor   = w_oor;
      w_src_blank = iBLANK_LZ;
      w_slot      = '0;
    end
  end

  // Character selection, clipping and leading-zero blanking for the slot being emitted.
  always_comb begin
    w_char = ASCII_SPACE;
    for (int k = 0; k < NCHARS; k++) begin
      if (KW'(k) == w_slot) w_char = w_src_text[CHAR_W*k +: CHAR_W];
    end
    w_col_sum   = SW'(w_src_col) + SW'(w_slot);
    w_slot_we   = !w_src_oor && (w_col_sum < SW'(COLS));
    w_slot_addr = w_src_base + ADDRW'(w_slot);
    w_last      = (w_slot == KW'(NCHARS - 1));
    w_in_region = w_src_blank && is_lead_char(w_char);
    w_out_char  = (w_in_region && !w_last && (w_char == ASCII_ZERO)) ? ASCII_SPACE : w_char;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_blanking_nxt = r_blanking;
    w_ready_nxt    = r_ready;
    w_we_nxt       = 1'b0;
    w_done_nxt     = 1'b0;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = ST_WRITE;
          w_k_nxt        = '0;
          w_ready_nxt    = 1'b0;
          w_we_nxt       = w_slot_we;
          w_addr_nxt     = w_slot_addr;
          w_data_nxt     = w_out_char;
          w_done_nxt     = w_last;
          w_blanking_nxt = w_in_region;
        end
      end
      ST_WRITE: begin
        if (r_k == KW'(NCHARS - 1)) begin
          w_state_nxt    = ST_IDLE;
          w_k_nxt        = '0;
          w_ready_nxt    = 1'b1;
          w_blanking_nxt = 1'b0;
        end else begin
          w_k_nxt        = w_slot;
          w_we_nxt       = w_slot_we;
          w_addr_nxt     = w_slot_addr;
          w_data_nxt     = w_out_char;
          w_done_nxt     = w_last;
          w_blanking_nxt = w_in_region;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_blanking <= 1'b0;
      r_ready    <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= ASCII_SPACE;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_blanking <= w_blanking_nxt;
      r_ready    <= w_ready_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Request capture; only meaningful while a field is in flight.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_text <= '0;
      r_col  <= '0;
      r_base <= '0;
      r_oor  <= 1'b0;
    end else if (w_accept) begin
      r_text <= iTEXT;
      r_col  <= iCOL;
      r_base <= w_base;
      r_oor  <= w_oor;
    end
  end

  assign oREADY = r_ready;
  assign oWE    = r_we;
  assign oADDR  = r_addr;
  assign oDATA  = r_data;
  assign oDONE  = r_done;

endmodule

// File: tb/tb_text_field_writer.sv
// Directed self-checking bench for text_field_writer: one task per scenario,
// expected characters, addresses and timing written out by hand.
module tb_text_field_writer;

  logic        iCLK;
  logic        iRST_N;
  logic        iVALID;
  logic        oREADY;
  logic [47:0] iTEXT;
  logic [5:0]  iROW;
  logic [6:0]  iCOL;
  logic        iBLANK_LZ;
  logic        oWE;
  logic [12:0] oADDR;
  logic [7:0]  oDATA;
  logic        oDONE;

  int tests;
  int errors;

  text_field_writer dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iVALID    (iVALID),
    .oREADY    (oREADY),
    .iTEXT     (iTEXT),
    .iROW      (iROW),
    .iCOL      (iCOL),
    .iBLANK_LZ (iBLANK_LZ),
    .oWE       (oWE),
    .oADDR     (oADDR),
    .oDATA     (oDATA),
    .oDONE     (oDONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Char k of the string goes to bits [8k +: 8], k=0 leftmost.
  function automatic logic [47:0] pack(input string s);
    logic [47:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v[8*k +: 8] = s[k];
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (oREADY !== 1'b1 && n < 20) begin
      @(negedge iCLK);
      n++;
    end
    tests++;
    if (oREADY !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout got=%b exp=1", name, oREADY);
    end
  endtask

  // Checks one presented slot: write enable, address/data when writing, done, ready.
  task automatic check_slot(input string name, input int k, input bit exp_we,
                            input int exp_addr, input logic [7:0] exp_data);
    tests++;
    if (oWE !== exp_we) begin
      errors++;
      $display("FAIL %s we[%0d] got=%b exp=%b", name, k, oWE, exp_we);
    end
    if (exp_we) begin
      tests++;
      if (oADDR !== 13'(exp_addr)) begin
        errors++;
        $display("FAIL %s addr[%0d] got=%0d exp=%0d", name, k, oADDR, exp_addr);
      end
      tests++;
      if (oDATA !== exp_data) begin
        errors++;
        $display("FAIL %s data[%0d] got=%h exp=%h", name, k, oDATA, exp_data);
      end
    end
    tests++;
    if (oDONE !== (k == 5)) begin
      errors++;
      $display("FAIL %s done[%0d] got=%b exp=%b", name, k, oDONE, (k == 5));
    end
    tests++;
    if (oREADY !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_busy[%0d] got=%b exp=0", name, k, oREADY);
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (oREADY !== 1'b1 || oWE !== 1'b0 || oDONE !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got ready=%b we=%b done=%b exp ready=1 we=0 done=0",
               name, oREADY, oWE, oDONE);
    end
  endtask

  // Sends one field and checks its six slots plus the return to idle.
  task automatic run_field(input string name, input string txt, input int row, input int col,
                           input bit blz, input string exp, input bit [5:0] we_mask,
                           input int base);
    logic [7:0] c;
    @(negedge iCLK);
    wait_ready(name);
    iVALID    = 1'b1;
    iTEXT     = pack(txt);
    iROW      = 6'(row);
    iCOL      = 7'(col);
    iBLANK_LZ = blz;
    @(negedge iCLK);
    iVALID = 1'b0;
    for (int k = 0; k < 6; k++) begin
      c = exp[k];
      check_slot(name, k, we_mask[k], base + k, c);
      @(negedge iCLK);
    end
    check_idle(name);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iVALID = 1'b0; iTEXT = '0; iROW = '0; iCOL = '0; iBLANK_LZ = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    tests++;
    if (oREADY !== 1'b1 || oWE !== 1'b0 || oADDR !== 13'd0 || oDATA !== 8'h20 || oDONE !== 1'b0) begin
      errors++;
      $display("FAIL reset got ready=%b we=%b addr=%0d data=%h done=%b exp 1 0 0 20 0",
               oREADY, oWE, oADDR, oDATA, oDONE);
    end
    iRST_N = 1'b1;
  endtask

  task automatic test_basic();
    run_field("basic", " 00042", 2, 10, 1'b0, " 00042", 6'b111111, 170);
  endtask

  task automatic test_blanking();
    run_field("blank42",   " 00042", 2, 10, 1'b1, "    42", 6'b111111, 170);
    run_field("blankzero", " 00000", 5, 0,  1'b1, "     0", 6'b111111, 400);
    run_field("blankneg",  "-00042", 0, 0,  1'b1, "-00042", 6'b111111, 0);
    run_field("blankmix",  "0 0 07", 59, 74, 1'b1, "     7", 6'b111111, 4794);
    run_field("blankin",   "100200", 1, 1,  1'b1, "100200", 6'b111111, 81);
  endtask

  task automatic test_clip();
    run_field("clip77", "123456", 0, 77, 1'b0, "123456", 6'b000111, 77);
  endtask

  task automatic test_out_of_range();
    run_field("row60", "123456", 60, 0,  1'b0, "123456", 6'b000000, 0);
    run_field("col80", "123456", 0,  80, 1'b0, "123456", 6'b000000, 0);
  endtask

  task automatic test_back_to_back();
    string a, b;
    logic [7:0] c;
    a = "-12345";
    b = "987654";
    @(negedge iCLK);
    wait_ready("b2b");
    iVALID = 1'b1; iTEXT = pack(a); iROW = 6'd1; iCOL = 7'd0; iBLANK_LZ = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge iCLK);
      if (i == 0) begin
        iTEXT = pack(b);
        iCOL  = 7'd10;
      end
      if (i == 7) iVALID = 1'b0;
      if (i < 6) begin
        c = a[i];
        check_slot("b2b_a", i, 1'b1, 80 + i, c);
      end else if (i == 6 || i == 13) begin
        check_idle("b2b_gap");
      end else begin
        c = b[i - 7];
        check_slot("b2b_b", i - 7, 1'b1, 90 + i - 7, c);
      end
    end
  endtask

  task automatic test_busy_ignored();
    int we_cnt, done_cnt;
    string d;
    logic [7:0] c;
    d = "000111";
    we_cnt = 0; done_cnt = 0;
    @(negedge iCLK);
    wait_ready("busy");
    iVALID = 1'b1; iTEXT = pack(d); iROW = 6'd3; iCOL = 7'd0; iBLANK_LZ = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge iCLK);
      iVALID = 1'b0;
      if (i == 2) begin
        iVALID = 1'b1;
        iTEXT  = pack("999999");
        iCOL   = 7'd40;
      end
      if (i < 6) begin
        c = d[i];
        check_slot("busy", i, 1'b1, 240 + i, c);
      end
      if (oWE === 1'b1) we_cnt++;
      if (oDONE === 1'b1) done_cnt++;
    end
    tests++;
    if (we_cnt != 6 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_counts got we=%0d done=%0d exp we=6 done=1", we_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge iCLK);
    wait_ready("rstmid");
    iVALID = 1'b1; iTEXT = pack("555555"); iROW = 6'd4; iCOL = 7'd0; iBLANK_LZ = 1'b0;
    @(negedge iCLK);
    iVALID = 1'b0;
    repeat (3) @(negedge iCLK);
    tests++;
    if (oWE !== 1'b1 || oADDR !== 13'd323) begin
      errors++;
      $display("FAIL rstmid slot3 got we=%b addr=%0d exp we=1 addr=323", oWE, oADDR);
    end
    iRST_N = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    tests++;
    if (oWE !== 1'b0 || oREADY !== 1'b1 || oDONE !== 1'b0) begin
      errors++;
      $display("FAIL rstmid after got we=%b ready=%b done=%b exp 0 1 0", oWE, oREADY, oDONE);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      tests++;
      if (oWE !== 1'b0 || oDONE !== 1'b0) begin
        errors++;
        $display("FAIL rstmid quiet[%0d] got we=%b done=%b exp 0 0", i, oWE, oDONE);
      end
    end
    run_field("rstmid_new", "000123", 10, 20, 1'b1, "   123", 6'b111111, 820);
  endtask

  initial begin
    tests = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_blanking();
    test_clip();
    test_out_of_range();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
